// File: rtl/poll_scheduler_pkg.sv
// Shared types and constants for the poll scheduler and its tick prescaler.
package poll_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_e;

   // Channel index width; a single channel still needs one bit.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam logic   RST_FLAG  = 1'b0;
   localparam state_e RST_STATE = IDLE;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a registered one-cycle base tick every TICK_DIVISOR clocks.
module tick_prescaler
   import poll_scheduler_pkg::*;
#(
   parameter int unsigned TICK_DIVISOR      = 50000,
   parameter int unsigned TICK_COUNTER_SIZE = 16
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam logic [TICK_COUNTER_SIZE-1:0] LAST = TICK_COUNTER_SIZE'(TICK_DIVISOR - 1);

   logic [TICK_COUNTER_SIZE-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
         tick  <= RST_FLAG;
      end else if (count == LAST) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + TICK_COUNTER_SIZE'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/poll_scheduler.sv
// Periodic round-robin poll scheduler granting one shared sensor reader via start/done handshake.
module poll_scheduler
   import poll_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS      = 4,
   parameter int unsigned TICK_DIVISOR      = 50000,
   parameter int unsigned TICK_COUNTER_SIZE = 16,
   parameter int unsigned INTERVAL_SIZE     = 12,
   parameter int unsigned TIMEOUT_TICKS     = 20,
   localparam int unsigned CH_W             = ch_w(NUM_CHANNELS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_CHANNELS-1:0]  channel_mask,
   input  logic [INTERVAL_SIZE-1:0] interval,
   input  logic [NUM_CHANNELS-1:0]  poll_now,
   output logic                     reader_start,
   output logic [CH_W-1:0]          reader_channel,
   input  logic                     reader_done,
   input  logic                     reader_error,
   output logic                     tick,
   output logic                     busy,
   output logic                     fault,
   output logic [NUM_CHANNELS-1:0]  pending
);

   localparam int unsigned     TO_W     = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CH_W-1:0] LAST_RST = CH_W'(NUM_CHANNELS - 1);

   state_e                   state, state_next;
   logic [CH_W-1:0]          last_grant, last_grant_next, channel_next;
   logic [TO_W-1:0]          tmo_cnt, tmo_cnt_next;
   logic                     fault_next;
   logic [INTERVAL_SIZE-1:0] counter [NUM_CHANNELS];
   logic [INTERVAL_SIZE-1:0] reload;
   logic [NUM_CHANNELS-1:0]  granted, pend_set, pend_clr;
   logic                     sel_found;
   logic [CH_W-1:0]          sel_ch;
   int unsigned              idx;

   tick_prescaler #(
      .TICK_DIVISOR      (TICK_DIVISOR),
      .TICK_COUNTER_SIZE (TICK_COUNTER_SIZE)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   // An interval of 0 behaves as 1, i.e. reload with 0.
   always_comb begin
      reload = (interval == '0) ? '0 : interval - INTERVAL_SIZE'(1);
   end

   // Per-channel request set/clear terms; a set in the same cycle overrides a clear.
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         granted[i]  = (state != IDLE) && (reader_channel == CH_W'(i));
         pend_set[i] = enable && channel_mask[i] && ((tick && (counter[i] == '0)) || poll_now[i]);
         pend_clr[i] = ((state == START) && (reader_channel == CH_W'(i)))
                    || (!channel_mask[i] && !granted[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pending <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) counter[i] <= '0;
      end else begin
         pending <= (pending & ~pend_clr) | pend_set;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!channel_mask[i]) begin
               if (!granted[i]) counter[i] <= '0;
            end else if (enable && tick) begin
               counter[i] <= (counter[i] == '0) ? reload : counter[i] - INTERVAL_SIZE'(1);
            end
         end
      end
   end

   // Round-robin pick: first pending channel above the last one served.
   always_comb begin
      sel_found = 1'b0;
      sel_ch    = '0;
      idx       = '0;
      for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
         idx = 32'(last_grant) + k;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         if (!sel_found && pending[CH_W'(idx)]) begin
            sel_found = 1'b1;
            sel_ch    = CH_W'(idx);
         end
      end
   end

   always_comb begin
      state_next      = state;
      channel_next    = reader_channel;
      last_grant_next = last_grant;
      tmo_cnt_next    = tmo_cnt;
      fault_next      = 1'b0;
      case (state)
         IDLE: begin
            if (enable && sel_found) begin
               channel_next = sel_ch;
               state_next   = START;
            end
         end
         START: begin
            tmo_cnt_next = '0;
            state_next   = WAIT;
         end
         WAIT: begin
            if (reader_error || reader_done) begin
               fault_next      = reader_error;
               last_grant_next = reader_channel;
               state_next      = IDLE;
            end else if (tick) begin
               tmo_cnt_next = tmo_cnt + TO_W'(1);
               // A stuck channel still advances the round-robin pointer.
               if (tmo_cnt + TO_W'(1) == TO_W'(TIMEOUT_TICKS)) begin
                  fault_next      = 1'b1;
                  last_grant_next = reader_channel;
                  state_next      = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= RST_STATE;
         reader_channel <= '0;
         last_grant     <= LAST_RST;
         tmo_cnt        <= '0;
         reader_start   <= RST_FLAG;
         busy           <= RST_FLAG;
         fault          <= RST_FLAG;
      end else begin
         state          <= state_next;
         reader_channel <= channel_next;
         last_grant     <= last_grant_next;
         tmo_cnt        <= tmo_cnt_next;
         reader_start   <= (state_next == START);
         busy           <= (state_next != IDLE);
         fault          <= fault_next;
      end
   end

endmodule

// File: tb/tb_poll_scheduler.sv
// Directed bench for poll_scheduler with a cycle-level reference model checked every cycle.
module tb_poll_scheduler;

   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int TMO = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  channel_mask = '0;
   logic [11:0] interval = 12'd3;
   logic [3:0]  poll_now = '0;
   logic        reader_start;
   logic [1:0]  reader_channel;
   logic        reader_done = 1'b0;
   logic        reader_error = 1'b0;
   logic        tick, busy, fault;
   logic [3:0]  pending;

   poll_scheduler #(
      .NUM_CHANNELS      (N),
      .TICK_DIVISOR      (DIV),
      .TICK_COUNTER_SIZE (16),
      .INTERVAL_SIZE     (12),
      .TIMEOUT_TICKS     (TMO)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .channel_mask   (channel_mask),
      .interval       (interval),
      .poll_now       (poll_now),
      .reader_start   (reader_start),
      .reader_channel (reader_channel),
      .reader_done    (reader_done),
      .reader_error   (reader_error),
      .tick           (tick),
      .busy           (busy),
      .fault          (fault),
      .pending        (pending)
   );

   initial forever #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   function automatic void check(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
      end
   endfunction

   // Cycles since reset release: cycle 1 is the first clock with reset high.
   always @(posedge clock) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Reference model: prescaler phase, ticks-to-expiry per channel, request set, transaction phase.
   int       m_pc, m_left [N], m_phase, m_last, m_ch, m_tcnt;
   bit       m_tick, m_start, m_busy, m_fault;
   bit [3:0] m_pend;

   always @(posedge clock) begin : model
      bit [3:0] set_v, clr_v;
      bit       found;
      int       c;
      if (!reset) begin
         m_pc = 0; m_tick = 0; m_pend = '0; m_phase = 0; m_last = N - 1;
         m_ch = 0; m_tcnt = 0; m_start = 0; m_busy = 0; m_fault = 0;
         for (int i = 0; i < N; i++) m_left[i] = 0;
      end else begin
         set_v = '0;
         clr_v = '0;
         for (int i = 0; i < N; i++) begin
            if (channel_mask[i]) begin
               if (enable && m_tick) begin
                  if (m_left[i] == 0) begin
                     set_v[i]  = 1'b1;
                     m_left[i] = (interval == 0) ? 0 : int'(interval) - 1;
                  end else begin
                     m_left[i] = m_left[i] - 1;
                  end
               end
               if (enable && poll_now[i]) set_v[i] = 1'b1;
            end else if (!(m_phase != 0 && m_ch == i)) begin
               m_left[i] = 0;
               clr_v[i]  = 1'b1;
            end
         end
         if (m_phase == 1) clr_v[m_ch] = 1'b1;
         m_fault = 0;
         case (m_phase)
            0: if (enable) begin
                  found = 0;
                  for (int k = 1; k <= N; k++) begin
                     c = (m_last + k) % N;
                     if (!found && m_pend[c]) begin
                        found = 1; m_ch = c; m_phase = 1;
                     end
                  end
               end
            1: begin m_phase = 2; m_tcnt = 0; end
            default: begin
               if (reader_error || reader_done) begin
                  m_fault = reader_error; m_last = m_ch; m_phase = 0;
               end else if (m_tick) begin
                  m_tcnt++;
                  if (m_tcnt == TMO) begin
                     m_fault = 1; m_last = m_ch; m_phase = 0;
                  end
               end
            end
         endcase
         m_pend  = (m_pend & ~clr_v) | set_v;
         m_start = (m_phase == 1);
         m_busy  = (m_phase != 0);
         m_tick  = (m_pc == DIV - 1);
         m_pc    = (m_pc + 1) % DIV;
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         check("tick", tick, m_tick);
         check("reader_start", reader_start, m_start);
         check("reader_channel", reader_channel, m_ch);
         check("busy", busy, m_busy);
         check("fault", fault, m_fault);
         check("pending", pending, m_pend);
      end
   end

   // Event log used by the hand-computed timing checks.
   int n_starts = 0, last_start_cyc = -1, last_start_ch = -1;
   int last_tick_cyc = -1, last_fault_cyc = -1;

   always @(negedge clock) begin
      if (tick) last_tick_cyc = cyc;
      if (fault) last_fault_cyc = cyc;
      if (reader_start) begin
         n_starts++;
         last_start_cyc = cyc;
         last_start_ch  = reader_channel;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scripted reader: answers resp_delay cycles after a start (0 = never answers).
   int resp_delay = 0, countdown = 0;
   bit resp_done = 1'b1, resp_err = 1'b0;

   initial forever begin
      step();
      reader_done  = 1'b0;
      reader_error = 1'b0;
      if (!reset) countdown = 0;
      else if (countdown > 0) begin
         countdown--;
         if (countdown == 0) begin
            reader_done  = resp_done;
            reader_error = resp_err;
         end
      end else if (reader_start && resp_delay > 0) countdown = resp_delay;
   end

   task automatic goto(input int n);
      int k = 0;
      while (cyc < n && k < 1000) begin step(); k++; end
      check("goto_cycle", cyc, n);
   endtask

   task automatic wait_start(input string nm, input int budget, output int scyc, output int sch);
      int n0 = n_starts;
      int k = 0;
      while (n_starts == n0 && k < budget) begin step(); k++; end
      check({nm, "_seen"}, int'(n_starts != n0), 1);
      scyc = last_start_cyc;
      sch  = last_start_ch;
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b0; channel_mask = '0; poll_now = '0; interval = 12'd3;
      resp_delay = 0; resp_done = 1'b1; resp_err = 1'b0;
      repeat (3) step();
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int sc, sch, prev, n0;
      reset = 1'b0;
      step();
      check_en = 1'b1;

      // Reset, tick spacing, periodic polling, reset mid-transaction
      do_reset();
      step();
      check("rst_busy", busy, 0);
      check("rst_pending", pending, 0);
      goto(5);
      check("first_tick_cyc", last_tick_cyc, 4);
      goto(9);
      check("second_tick_cyc", last_tick_cyc, 8);
      channel_mask = 4'b0001; enable = 1'b1; resp_delay = 5;
      wait_start("p1", 40, sc, sch);
      check("p1_cyc", sc, 14);
      check("p1_ch", sch, 0);
      prev = sc;
      for (int p = 2; p <= 3; p++) begin
         wait_start("pn", 40, sc, sch);
         check("p_period", sc - prev, 12);
         check("p_after_tick", sc - last_tick_cyc, 2);
         check("p_ch", sch, 0);
         prev = sc;
      end
      goto(40);
      check("busy_midwait", busy, 1);
      reset = 1'b0;
      step();
      check("busy_after_reset", busy, 0);

      // Round-robin order, then immediate polls after last_grant=3
      do_reset();
      interval = 12'd100; channel_mask = 4'b1111; enable = 1'b1; resp_delay = 3;
      for (int g = 0; g < 4; g++) begin
         wait_start("rr", 40, sc, sch);
         check("rr_order", sch, g);
      end
      goto(27);
      check("rr_pend_empty", pending, 0);
      poll_now = 4'b1001;
      step();
      poll_now = '0;
      wait_start("pn_a", 20, sc, sch);
      check("pn_first_ch", sch, 0);
      wait_start("pn_b", 20, sc, sch);
      check("pn_second_ch", sch, 3);

      // Timeout on channel 1 moves service on to channel 2
      do_reset();
      channel_mask = 4'b0110; enable = 1'b1;
      wait_start("to1", 20, sc, sch);
      check("to_first_ch", sch, 1);
      check("to_first_cyc", sc, 6);
      goto(13);
      check("to_fault", fault, 1);
      check("to_busy", busy, 0);
      wait_start("to2", 20, sc, sch);
      check("to_next_ch", sch, 2);
      check("to_next_cyc", sc, 14);

      // Done+error together, then expiry landing in the START cycle
      do_reset();
      interval = 12'd4; channel_mask = 4'b0001; enable = 1'b1;
      resp_delay = 3; resp_err = 1'b1;
      goto(10);
      check("err_fault_on", fault, 1);
      goto(11);
      check("err_fault_off", fault, 0);
      check("err_fault_cyc", last_fault_cyc, 10);
      goto(18);
      poll_now = 4'b0001;
      step();
      poll_now = '0;
      goto(20);
      check("prio_start", reader_start, 1);
      check("prio_tick", tick, 1);
      goto(21);
      check("prio_pending", pending, 4'b0001);

      // Masking a pending channel drops its request
      do_reset();
      channel_mask = 4'b0110; enable = 1'b1;
      goto(7);
      check("mask_pend_before", pending, 4'b0100);
      channel_mask = 4'b0010;
      goto(8);
      check("mask_pend_cleared", pending, 0);
      n0 = n_starts;
      goto(17);
      check("mask_no_grant", n_starts - n0, 0);

      // Disable mid-transaction: it completes, new grants wait for enable
      do_reset();
      interval = 12'd100; channel_mask = 4'b0011; enable = 1'b1; resp_delay = 6;
      wait_start("en1", 20, sc, sch);
      check("en1_ch", sch, 0);
      enable = 1'b0;
      n0 = n_starts;
      goto(13);
      check("en_done_busy", busy, 0);
      goto(31);
      check("en_blocked", n_starts - n0, 0);
      check("en_pend_held", pending, 4'b0010);
      enable = 1'b1;
      wait_start("en2", 10, sc, sch);
      check("en2_cyc", sc, 32);
      check("en2_ch", sch, 1);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
